// File: rtl/sys_defs_pkg.sv
// Shared result/CDB types and machine-wide constants.
// Imported by every unit that produces or consumes CDB traffic.
package sys_defs;

  localparam int PRN_W = 6;
  localparam int ROB_W = 5;
  localparam int XLEN  = 32;

  localparam logic [PRN_W-1:0] ZERO_REG = 6'd31;

  localparam int CDB_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [PRN_W-1:0] PRN_index;
    logic [ROB_W-1:0] ROB_index;
    logic             thread_ID;
    logic             FU_done;
  } FU_RESULT;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [PRN_W-1:0] tag;
    logic             thread_ID;
    logic             valid;
  } CDB;

  function automatic FU_RESULT fu_empty();
    FU_RESULT r;
    r           = '0;
    r.PRN_index = ZERO_REG;
    return r;
  endfunction

endpackage

// File: rtl/cdb_result_queue.sv
// Per-FU result queue feeding the CDB arbiter; pops on grant, squashes per thread.
// Ports: clock, reset (sync, active-low), fu_in, mispredict_0/1, sent -> cdb_req, full, count.
module cdb_result_queue
  import sys_defs::*;
#(
  parameter int DEPTH = CDB_QUEUE_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  FU_RESULT                   fu_in,
  input  logic                       mispredict_0,
  input  logic                       mispredict_1,
  input  logic                       sent,
  output FU_RESULT                   cdb_req,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  FU_RESULT         q     [DEPTH];
  FU_RESULT         q_nxt [DEPTH];
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    wr;
  logic             in_sq;
  logic             push;

  always_comb begin
    keep = '0;
    wr   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = '0;
    end
    // Pop and squash fold into one keep mask, so an entry hit by
    // both is still removed only once.
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = (CW'(i) < count)
             && !(sent && i == 0)
             && !(q[i].thread_ID ? mispredict_1 : mispredict_0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        q_nxt[wr[IW-1:0]] = q[i];
        wr = wr + CW'(1);
      end
    end
    in_sq = fu_in.thread_ID ? mispredict_1 : mispredict_0;
    // full is the pre-update value: freed slots are not reused this cycle.
    push  = fu_in.FU_done && !full && !in_sq;
    if (push) begin
      q_nxt[wr[IW-1:0]]         = fu_in;
      q_nxt[wr[IW-1:0]].FU_done = 1'b1;
      wr = wr + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= wr;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign cdb_req = (count == '0) ? fu_empty() : q[0];

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed bench for cdb_result_queue.
// Drives inputs 1ns after each rising edge and checks registered outputs there.
module tb_cdb_result_queue;
  import sys_defs::*;

  localparam int D  = CDB_QUEUE_DEPTH;
  localparam int CW = $clog2(D+1);

  logic          clock;
  logic          reset;
  FU_RESULT      fu_in;
  logic          mispredict_0;
  logic          mispredict_1;
  logic          sent;
  FU_RESULT      cdb_req;
  logic          full;
  logic [CW-1:0] count;

  int n_cmp;
  int n_err;

  cdb_result_queue #(.DEPTH(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .fu_in        (fu_in),
    .mispredict_0 (mispredict_0),
    .mispredict_1 (mispredict_1),
    .sent         (sent),
    .cdb_req      (cdb_req),
    .full         (full),
    .count        (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic FU_RESULT mk(input int prn, input logic tid);
    FU_RESULT r;
    r           = '0;
    r.result    = XLEN'(prn * 100);
    r.PRN_index = PRN_W'(prn);
    r.ROB_index = ROB_W'(prn);
    r.thread_ID = tid;
    r.FU_done   = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int prn, input logic tid);
    fu_in = mk(prn, tid);
    tick();
    fu_in = '0;
  endtask

  task automatic head(input string tag, input int prn, input int cnt);
    chk({tag, ".cnt"}, 64'(count), 64'(cnt));
    chk({tag, ".prn"}, 64'(cdb_req.PRN_index), 64'(prn));
    chk({tag, ".vld"}, 64'(cdb_req.FU_done), 64'(1));
  endtask

  task automatic empty(input string tag);
    chk({tag, ".cnt"}, 64'(count), 64'(0));
    chk({tag, ".prn"}, 64'(cdb_req.PRN_index), 64'(31));
    chk({tag, ".vld"}, 64'(cdb_req.FU_done), 64'(0));
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b0;
    sent         = 1'b1;
    mispredict_0 = 1'b0;
    mispredict_1 = 1'b0;
    fu_in        = mk(5, 1'b0);
    tick();
    tick();
    empty("rst");
    chk("rst.full", 64'(full), 64'(0));
    chk("rst.res", 64'(cdb_req.result), 64'(0));
    reset = 1'b1;
    sent  = 1'b0;
    fu_in = '0;
    tick();

    push(5, 1'b0);
    head("lat", 5, 1);
    push(6, 1'b0);
    push(7, 1'b0);
    head("p3", 5, 3);
    chk("p3.res", 64'(cdb_req.result), 64'(500));
    sent = 1'b1;
    tick();
    head("pop1", 6, 2);
    tick();
    head("pop2", 7, 1);
    tick();
    empty("pop3");
    tick();
    empty("popE");
    sent = 1'b0;

    push(10, 1'b0);
    push(11, 1'b0);
    push(12, 1'b0);
    push(13, 1'b0);
    chk("fill.full", 64'(full), 64'(1));
    head("fill", 10, 4);
    push(9, 1'b0);
    head("ovf", 10, 4);
    sent = 1'b1;
    push(9, 1'b0);
    head("ovfpop", 11, 3);
    chk("ovfpop.full", 64'(full), 64'(0));
    tick();
    head("dr1", 12, 2);
    tick();
    head("dr2", 13, 1);
    tick();
    empty("dr3");
    sent = 1'b0;

    push(1, 1'b0);
    push(2, 1'b1);
    push(3, 1'b0);
    push(4, 1'b1);
    head("thr", 1, 4);
    mispredict_0 = 1'b1;
    tick();
    head("sq0", 2, 2);
    chk("sq0.full", 64'(full), 64'(0));
    push(7, 1'b0);
    head("sq0p0", 2, 2);
    push(8, 1'b1);
    head("sq0p1", 2, 3);
    mispredict_0 = 1'b0;
    sent = 1'b1;
    tick();
    head("o1", 4, 2);
    tick();
    head("o2", 8, 1);
    tick();
    empty("o3");
    sent = 1'b0;

    push(20, 1'b1);
    push(21, 1'b0);
    push(22, 1'b1);
    head("hs", 20, 3);
    sent         = 1'b1;
    mispredict_1 = 1'b1;
    tick();
    head("hs1", 21, 1);
    chk("hs1.tid", 64'(cdb_req.thread_ID), 64'(0));
    mispredict_1 = 1'b0;
    tick();
    empty("hs2");
    sent = 1'b0;

    push(30, 1'b0);
    push(33, 1'b1);
    head("both", 30, 2);
    mispredict_0 = 1'b1;
    mispredict_1 = 1'b1;
    push(34, 1'b1);
    empty("both1");
    mispredict_0 = 1'b0;
    mispredict_1 = 1'b0;
    tick();
    empty("both2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_result_queue.md
# cdb_result_queue

Per-functional-unit output queue on the transmit side of the CDB arbitration handshake. Captures completed `FU_RESULT`s from one FU, presents the oldest as a request to `CDB_arbiter`, and pops it on that FU's `*_sent` grant. Squashes queued results of a mispredicted thread so the arbiter never sees them. One instance sits between each ALU/mult output and the arbiter, so an FU is never stalled by a lost arbitration unless its queue fills.

## Interface
- `DEPTH`, 4: queue entries, ≥2.
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge clears the block
- `fu_in`  in  `FU_RESULT`  result from the FU; `fu_in.FU_done` qualifies it
- `mispredict_0`  in  1  squash all thread-0 results
- `mispredict_1`  in  1  squash all thread-1 results
- `sent`  in  1  arbiter grant for the current head (the matching `ALU_x_sent`/`mult_sent`)
- `cdb_req`  out  `FU_RESULT`  head entry to arbiter; `FU_done=1` iff queue non-empty
- `full`  out  1  `count==DEPTH`; FU must hold its result
- `count`  out  `$clog2(DEPTH+1)`  occupied entries

## Operation
- Storage: `DEPTH` entries plus `count`, kept compacted in age order; entry 0 is the head (oldest).
- Every cycle, next state:
  1. Drop the head if `sent && count!=0`.
  2. Drop every remaining entry with (`thread_ID==0 && mispredict_0`) or (`thread_ID==1 && mispredict_1`).
  3. Compact survivors toward entry 0, preserving order.
  4. Append `fu_in` at the first free slot if `fu_in.FU_done && !full` and `fu_in` is not of a squashed thread this cycle.
- `full` is evaluated on the current (pre-update) `count`; a slot freed by a pop or squash in the same cycle is not usable until the next cycle (no bypass).
- `fu_in.FU_done` while `full`: the input is ignored and state is unchanged by it. The FU must not do this; it is a checker error.
- `sent` while empty: ignored.
- `sent` together with squash of the head's thread: the entry is removed exactly once and `count` decrements by 1 for it.
- Both mispredicts in the same cycle: the queue empties and the input is dropped.
- `cdb_req` when empty: all fields 0, `PRN_index=ZERO_REG`, `FU_done=0`.
- Stored `FU_done` is forced to 1; unused tail entries are zeroed.

## Timing
- Reset: `count=0`, `full=0`, `cdb_req` = empty value above; takes effect at the first rising edge with `reset==0`, overriding same-cycle push, pop and squash.
- Push-to-request latency is 1 cycle: a result accepted at edge N is on `cdb_req` after edge N, even if the queue was empty (no combinational `fu_in`→`cdb_req` path).
- `sent` is combinational from the arbiter in the same cycle `cdb_req` is valid; the next entry appears after the following edge. Throughput is 1 result/cycle.
- Squash completes in 1 cycle. After the edge where `mispredict_t` was high, no thread-t entry remains.
- `cdb_req`, `full` and `count` are register-only outputs, with no combinational dependence on any input.

## Structure
- `FU_RESULT`, `CDB` and `ZERO_REG` come from the shared sys_defs package/header. Add `CDB_QUEUE_DEPTH` there as the default for `DEPTH`.
- Single module. Compaction is a for-loop over a keep mask inside `always_comb`, with one `always_ff` for entries and `count`. No sub-module is needed.

## Test plan
- Reset: hold `reset=0` with `fu_in.FU_done=1` → `count=0`, `cdb_req.PRN_index=ZERO_REG`, `FU_done=0`.
- Push PRN 5, 6, 7 (thread 0) on consecutive cycles with `sent=0` → `count=3`, head PRN 5. Then `sent=1` for 3 cycles → heads 6, 7, then empty.
- Fill to 4 → `full=1`. Push PRN 9 while full → ignored. `sent=1` and push in the same cycle → push still rejected, `count=3`.
- Queue threads [0,1,0,1] with PRNs 1–4, pulse `mispredict_0` → `count=2`, order PRN 2 then 4. Same-cycle thread-0 push is dropped, thread-1 push is accepted as entry 2.
- Head is thread 1, `sent=1` and `mispredict_1=1` together with one other thread-1 entry and one thread-0 entry → only the thread-0 entry remains, `count=1`.
- Push with `mispredict_0=mispredict_1=1` → `count=0`, `cdb_req.FU_done=0` next cycle.
